vpe_feature_dispatch: RTL and testbench

- Producer end of the packet-feature interface that feeds the eight-VPE cluster.
- Buffers 256-bit packet feature vectors from the parser in a FIFO and serves the cluster's fetch requests, one feature per request.
- Drives the shared pkt_feature bus and the one-hot vpe_mux_valid strobe, steering each feature to VPEs in round-robin order.

---
 rtl/vpe_feature_dispatch.sv | 130 +++++++++++++
 tb/tb_vpe_feature_dispatch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vpe_feature_dispatch.sv
// vpe_feature_dispatch
//   Producer side of the packet-feature interface for the eight-VPE cluster.
//   Feature vectors from the parser are buffered in a FIFO. Each cluster
//   fetch request is served with one feature on the shared pkt_feature bus.
//   A one-hot vpe_mux_valid strobe names the capturing VPE, and the VPEs are
//   selected in round-robin order. Fetches that arrive while the FIFO is
//   empty are banked as credit, up to CREDIT_MAX.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   in_feature/valid   parser write side
//   in_ready           high while the FIFO is not full
//   fetch_pkt_feature  OR of all VPE fetch requests
//   pkt_feature        feature bus; holds its value between issues
//   vpe_mux_valid      one-cycle one-hot capture strobe
//   fifo_count         current FIFO occupancy
//   issued_cnt         wrapping count of issued features
module vpe_feature_dispatch #(
  parameter int FEAT_W     = 256,
  parameter int NUM_VPE    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CREDIT_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FEAT_W-1:0]             in_feature,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          fetch_pkt_feature,
  output logic [FEAT_W-1:0]             pkt_feature,
  output logic [NUM_VPE-1:0]            vpe_mux_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   issued_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = (NUM_VPE > 1) ? $clog2(NUM_VPE) : 1;
  localparam int CW = $clog2(CREDIT_MAX + 1);

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [RW-1:0] RR_LAST_C = RW'(NUM_VPE - 1);
  localparam logic [CW-1:0] CRED_MAX_C = CW'(CREDIT_MAX);

  logic [FEAT_W-1:0]  mem_r [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic [RW-1:0]      rr_ptr_r;
  logic [CW-1:0]      credit_r;
  logic [CW-1:0]      credit_nxt_s;
  logic [AW:0]        count_s;
  logic               empty_s;
  logic               full_s;
  logic               push_s;
  logic               issue_s;

  // Occupancy comes from the extra-MSB pointers only, so in_ready has no
  // path from in_valid and a same-cycle push is never issuable.
  assign count_s    = wr_ptr_r - rd_ptr_r;
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (count_s == DEPTH_C);
  assign in_ready   = !full_s;
  assign fifo_count = count_s;

  assign push_s  = in_valid && !full_s;
  assign issue_s = ((credit_r != CW'(0)) || fetch_pkt_feature) && !empty_s;

  // Credit next-state: fetch adds (saturating), issue consumes; both cancel.
  always_comb begin
    credit_nxt_s = credit_r;
    if (fetch_pkt_feature && !issue_s) begin
      if (credit_r == CRED_MAX_C) begin
        credit_nxt_s = credit_r;
      end else begin
        credit_nxt_s = credit_r + CW'(1);
      end
    end else if (!fetch_pkt_feature && issue_s) begin
      credit_nxt_s = credit_r - CW'(1);
    end else begin
      credit_nxt_s = credit_r;
    end
  end

  // Feature storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= in_feature;
    end
  end

  // FIFO pointers, credit and round-robin state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      credit_r <= '0;
      rr_ptr_r <= '0;
    end else begin
      credit_r <= credit_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        if (rr_ptr_r == RR_LAST_C) begin
          rr_ptr_r <= '0;
        end else begin
          rr_ptr_r <= rr_ptr_r + RW'(1);
        end
      end
    end
  end

  // Registered issue outputs: head data, one-hot strobe, issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_feature   <= '0;
      vpe_mux_valid <= '0;
      issued_cnt    <= 32'd0;
    end else begin
      if (issue_s) begin
        pkt_feature   <= mem_r[rd_ptr_r[AW-1:0]];
        vpe_mux_valid <= NUM_VPE'(1) << rr_ptr_r;
        issued_cnt    <= issued_cnt + 32'd1;
      end else begin
        vpe_mux_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vpe_feature_dispatch.sv
// Directed self-checking bench for vpe_feature_dispatch.
module tb_vpe_feature_dispatch;

  localparam int FEAT_W = 256;
  localparam int NUM_VPE = 8;
  localparam int FIFO_DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FEAT_W-1:0] in_feature = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              fetch_pkt_feature = 1'b0;
  logic [FEAT_W-1:0] pkt_feature;
  logic [NUM_VPE-1:0] vpe_mux_valid;
  logic [4:0]        fifo_count;
  logic [31:0]       issued_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_rr = 0;
  int exp_issued = 0;
  int strobes;

  vpe_feature_dispatch #(
    .FEAT_W(FEAT_W), .NUM_VPE(NUM_VPE), .FIFO_DEPTH(FIFO_DEPTH), .CREDIT_MAX(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_feature(in_feature), .in_valid(in_valid), .in_ready(in_ready),
    .fetch_pkt_feature(fetch_pkt_feature),
    .pkt_feature(pkt_feature), .vpe_mux_valid(vpe_mux_valid),
    .fifo_count(fifo_count), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [FEAT_W-1:0] got,
                           input logic [FEAT_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    fetch_pkt_feature = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_rr = 0;
    exp_issued = 0;
  endtask

  // Expect a strobe this cycle carrying data d; advances the rr model.
  task automatic expect_strobe(input string tag, input logic [FEAT_W-1:0] d);
    logic [NUM_VPE-1:0] oh;
    oh = NUM_VPE'(1) << exp_rr;
    check_val({tag, "_strobe"}, FEAT_W'(vpe_mux_valid), FEAT_W'(oh));
    check_val({tag, "_data"}, pkt_feature, d);
    exp_rr = (exp_rr + 1) % NUM_VPE;
    exp_issued++;
  endtask

  initial begin
    // ---- 1. reset values and mid-run reset ----
    tick();
    tick();
    check_val("rst_pkt", pkt_feature, '0);
    check_val("rst_vmv", FEAT_W'(vpe_mux_valid), '0);
    check_val("rst_cnt", FEAT_W'(fifo_count), '0);
    check_val("rst_iss", FEAT_W'(issued_cnt), '0);
    check_val("rst_rdy", FEAT_W'(in_ready), FEAT_W'(1));
    rst = 1'b0;
    tick();
    fetch_pkt_feature = 1'b1;
    repeat (3) tick();
    fetch_pkt_feature = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_feature = FEAT_W'(32'hF0 + i);
      tick();
      if (i == 0) check_val("t1_nostrobe", FEAT_W'(vpe_mux_valid), '0);
      else if (i < 3) expect_strobe("t1", FEAT_W'(32'hF0 + i - 1));
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("t1_async_vmv", FEAT_W'(vpe_mux_valid), '0);
    check_val("t1_async_pkt", pkt_feature, '0);
    check_val("t1_async_cnt", FEAT_W'(fifo_count), '0);
    check_val("t1_async_iss", FEAT_W'(issued_cnt), '0);
    check_val("t1_async_rdy", FEAT_W'(in_ready), FEAT_W'(1));
    tick();
    rst = 1'b0;
    tick();
    fetch_pkt_feature = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("t1_post_fetch", FEAT_W'(vpe_mux_valid), '0);
    end
    fetch_pkt_feature = 1'b0;
    tick();
    check_val("t1_post_idle", FEAT_W'(vpe_mux_valid), '0);

    // ---- 2. basic issue and round-robin ----
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_feature = FEAT_W'(32'hA1 + i);
      tick();
      check_val("t2_fill_nostrobe", FEAT_W'(vpe_mux_valid), '0);
    end
    in_valid = 1'b0;
    check_val("t2_count9", FEAT_W'(fifo_count), FEAT_W'(9));
    fetch_pkt_feature = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      expect_strobe("t2", FEAT_W'(32'hA1 + i));
    end
    fetch_pkt_feature = 1'b0;
    tick();
    check_val("t2_idle", FEAT_W'(vpe_mux_valid), '0);
    check_val("t2_hold", pkt_feature, FEAT_W'(32'hA9));
    check_val("t2_issued", FEAT_W'(issued_cnt), FEAT_W'(9));
    check_val("t2_empty", FEAT_W'(fifo_count), '0);

    // ---- 3. credit banking ----
    fetch_pkt_feature = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t3_bank", FEAT_W'(vpe_mux_valid), '0);
    end
    fetch_pkt_feature = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_feature = FEAT_W'(32'hB0 + i);
      tick();
      if (i == 0) check_val("t3_first_push", FEAT_W'(vpe_mux_valid), '0);
      else expect_strobe("t3", FEAT_W'(32'hB0 + i - 1));
    end
    in_valid = 1'b0;
    tick();
    expect_strobe("t3", FEAT_W'(32'hB2));
    in_valid = 1'b1;
    in_feature = FEAT_W'(32'hB3);
    tick();
    check_val("t3_push4", FEAT_W'(vpe_mux_valid), '0);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("t3_no_credit", FEAT_W'(vpe_mux_valid), '0);
    end
    check_val("t3_count", FEAT_W'(fifo_count), FEAT_W'(1));
    check_val("t3_issued", FEAT_W'(issued_cnt), FEAT_W'(exp_issued));

    // ---- 4. credit saturation ----
    do_reset();
    fetch_pkt_feature = 1'b1;
    repeat (12) tick();
    fetch_pkt_feature = 1'b0;
    strobes = 0;
    for (int i = 0; i < 15; i++) begin
      in_valid = (i < 12);
      in_feature = FEAT_W'(32'hC0 + i);
      tick();
      if (vpe_mux_valid != '0) begin
        expect_strobe("t4", FEAT_W'(32'hC0 + strobes));
        strobes++;
      end
    end
    in_valid = 1'b0;
    check_val("t4_strobes", FEAT_W'(strobes), FEAT_W'(8));
    check_val("t4_count", FEAT_W'(fifo_count), FEAT_W'(4));
    check_val("t4_issued", FEAT_W'(issued_cnt), FEAT_W'(8));

    // ---- 5. full FIFO ----
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_feature = FEAT_W'(32'hD00 + i);
      tick();
    end
    check_val("t5_full_rdy", FEAT_W'(in_ready), '0);
    check_val("t5_full_cnt", FEAT_W'(fifo_count), FEAT_W'(16));
    in_feature = FEAT_W'(32'hD10);
    tick();
    check_val("t5_held_cnt", FEAT_W'(fifo_count), FEAT_W'(16));
    check_val("t5_held_rdy", FEAT_W'(in_ready), '0);
    fetch_pkt_feature = 1'b1;
    tick();
    fetch_pkt_feature = 1'b0;
    expect_strobe("t5", FEAT_W'(32'hD00));
    check_val("t5_pop_cnt", FEAT_W'(fifo_count), FEAT_W'(15));
    check_val("t5_pop_rdy", FEAT_W'(in_ready), FEAT_W'(1));
    tick();
    in_valid = 1'b0;
    check_val("t5_accept_cnt", FEAT_W'(fifo_count), FEAT_W'(16));
    fetch_pkt_feature = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      expect_strobe("t5_drain", FEAT_W'(32'hD00 + i));
    end
    fetch_pkt_feature = 1'b0;
    tick();
    check_val("t5_drained", FEAT_W'(fifo_count), '0);

    // ---- 6. concurrent push/pop ----
    do_reset();
    strobes = 0;
    for (int i = 0; i < 102; i++) begin
      in_valid = (i < 100);
      fetch_pkt_feature = (i < 100);
      in_feature = FEAT_W'(32'hE00 + i);
      tick();
      check_val("t6_occ", FEAT_W'(fifo_count > 5'd1), '0);
      if (vpe_mux_valid != '0) begin
        expect_strobe("t6", FEAT_W'(32'hE00 + strobes));
        strobes++;
      end
    end
    in_valid = 1'b0;
    fetch_pkt_feature = 1'b0;
    check_val("t6_strobes", FEAT_W'(strobes), FEAT_W'(100));
    check_val("t6_issued", FEAT_W'(issued_cnt), FEAT_W'(100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
